// File: rtl/arith_pkg.sv
// Shared constants, op codes and FSM state type for the BETA ALU arithmetic stage.
// ARITH_FAST_MUL_EN selects the radix-4 multiplier (16 iterations) instead of radix-2 (32).
package arith_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] AFN_ADD = 2'b00;
  localparam logic [1:0] AFN_SUB = 2'b01;
  localparam logic [1:0] AFN_MUL = 2'b10;
  localparam logic [1:0] AFN_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

`ifdef ARITH_FAST_MUL_EN
  localparam int MUL_CYCLES    = 16;
  localparam int MUL_STEP_BITS = 2;
`else
  localparam int MUL_CYCLES    = 32;
  localparam int MUL_STEP_BITS = 1;
`endif

  localparam int CNT_W = 6;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier core; returns the low WIDTH bits of a*b.
// ARITH_FAST_MUL_EN retires two multiplier bits per step instead of one.
module mul_iter
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] partial;

`ifdef ARITH_FAST_MUL_EN
  always_comb begin
    partial = '0;
    case (mplier_q[1:0])
      2'b01:   partial = mcand_q;
      2'b10:   partial = mcand_q << 1;
      2'b11:   partial = mcand_q + (mcand_q << 1);
      default: partial = '0;
    endcase
  end
`else
  always_comb begin
    partial = mplier_q[0] ? mcand_q : '0;
  end
`endif

  // Down-counter of remaining steps; terminal count (zero) means the product is complete.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(MUL_CYCLES);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << MUL_STEP_BITS;
      mplier_d = mplier_q >> MUL_STEP_BITS;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done    = (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/arith_stage.sv
// BETA ALU arithmetic stage: add/sub in one cycle, iterative multiply, registered result and Z/V/N.
// ARITH_FAST_MUL_EN (see arith_pkg) halves the multiply iteration count.
//
// state   | meaning
// IDLE    | ready to accept an operation
// MUL     | multiplier core iterating
// DONE    | result and flags valid, waiting for out_ready
module arith_stage
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       afn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
  output logic             n
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             n_q, n_d;

  logic             accept;
  logic             is_mul;
  logic             is_sub;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic             sum_v;

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign is_mul    = (afn == AFN_MUL);
  assign is_sub    = (afn == AFN_SUB);
  assign mul_start = accept && is_mul;

  mul_iter u_mul_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Reserved afn falls through to add.
  always_comb begin
    b_op = is_sub ? ~b : b;
    sum  = a + b_op + {{(WIDTH-1){1'b0}}, is_sub};
    if (is_sub)
      sum_v = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
    else
      sum_v = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_done)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    result_d = result_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    if (accept && !is_mul) begin
      result_d = sum;
      z_d      = (sum == '0);
      v_d      = sum_v;
      n_d      = sum[WIDTH-1];
    end else if (state_q == ST_MUL && mul_done) begin
      result_d = mul_product;
      z_d      = (mul_product == '0);
      v_d      = 1'b0;
      n_d      = mul_product[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      result_q <= result_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
    end
  end

  assign result = result_q;
  assign z      = z_q;
  assign v      = v_q;
  assign n      = n_q;

endmodule

// File: tb/tb_arith_stage.sv
// Self-checking bench for arith_stage: directed vector table, hand-written corner sequences,
// and randomized ops against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_arith_stage;

`ifdef ARITH_FAST_MUL_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  afn = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        z, v, n;

  int total = 0;
  int bad   = 0;

  arith_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .afn       (afn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .v         (v),
    .n         (n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  f;
    logic [31:0] r;
    logic        z;
    logic        v;
    logic        n;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: signed overflow from the true integer result, multiply via 64-bit product.
  function automatic logic [34:0] ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                            input logic [1:0] rf);
    longint      sa, sb, s;
    logic [63:0] p;
    logic [31:0] r;
    logic        ov;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    ov = 1'b0;
    if (rf == 2'b10) begin
      p = {32'd0, ra} * {32'd0, rb};
      r = p[31:0];
    end else if (rf == 2'b01) begin
      s  = sa - sb;
      r  = ra - rb;
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else begin
      s  = sa + sb;
      r  = ra + rb;
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {r, (r == 32'd0), ov, r[31]};
  endfunction

  // Issue one op with out_ready high; returns outputs and edges from accept to out_valid.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [1:0] tf,
                        output logic [31:0] rr, output logic rz, output logic rv,
                        output logic rn, output int lat);
    @(negedge clk);
    check("in_ready_before_op", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_; afn = tf; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    rr = result; rz = z; rv = v; rn = n;
    check("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] rr;
    logic        rz, rv, rn;
    int          lat;
    logic [34:0] exp;
    logic [31:0] ra, rb;
    logic [1:0]  rf;

    vecs[0]  = '{32'd5,         32'd5,         2'b01, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h80000000,  32'd1,         2'b01, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h7FFFFFFF,  32'd1,         2'b00, 32'h80000000, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{32'd3,         32'd4,         2'b00, 32'd7,        1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'd2,         32'd3,         2'b11, 32'd5,        1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'd0,         32'd1,         2'b01, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'hFFFFFFFF,  32'd1,         2'b00, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h80000000,  32'h80000000,  2'b00, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000FFFF,  32'h00010001,  2'b10, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{32'h00010000,  32'h00010000,  2'b10, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  2'b10, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'd7,         32'd6,         2'b10, 32'd42,       1'b0, 1'b0, 1'b0};

    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, z, v, n}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].f, rr, rz, rv, rn, lat);
      check($sformatf("vec%0d_result", i), rr, vecs[i].r);
      check($sformatf("vec%0d_zvn", i), {29'd0, rz, rv, rn},
            {29'd0, vecs[i].z, vecs[i].v, vecs[i].n});
      check($sformatf("vec%0d_latency", i), lat, (vecs[i].f == 2'b10) ? MUL_LAT : 0);
    end

    // Stall in DONE with operands wiggling; result must hold until handoff.
    @(negedge clk);
    out_ready = 1'b0;
    a = 32'd3; b = 32'd4; afn = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; afn = 2'($urandom_range(0, 3));
      check("stall_result", result, 32'd7);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("handoff_in_ready", {31'd0, in_ready}, 32'd1);
    check("handoff_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset asserted partway through a multiply.
    a = 32'h12345678; b = 32'h9ABCDEF1; afn = 2'b10; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mul_busy_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {29'd0, z, v, n}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd1, 32'd1, 2'b00, rr, rz, rv, rn, lat);
    check("post_rst_result", rr, 32'd2);
    check("post_rst_latency", lat, 0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rf = 2'($urandom_range(0, 3));
      if (i % 5 == 0) ra = {ra[31], 31'h7FFFFFFF};
      exp = ref_model(ra, rb, rf);
      run_op(ra, rb, rf, rr, rz, rv, rn, lat);
      check($sformatf("rnd%0d_result", i), rr, exp[34:3]);
      check($sformatf("rnd%0d_zvn", i), {29'd0, rz, rv, rn}, {29'd0, exp[2:0]});
      check($sformatf("rnd%0d_latency", i), lat, (rf == 2'b10) ? MUL_LAT : 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
